// File: rtl/therm_level_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : therm_level_seq_if
//  Purpose  : Request/level bundle between a requester and therm_level_seq.
//  Revision : 1.0  initial release
// ============================================================================
interface therm_level_seq_if #(
    parameter int LEVEL_W = 3
);
    logic               req_valid;
    logic [LEVEL_W-1:0] req_level;
    logic               req_ready;
    logic [LEVEL_W-1:0] dec_out;
    logic               enc_en;
    logic               busy;
    logic               done;

    modport master (
        output req_valid, req_level,
        input  req_ready, dec_out, enc_en, busy, done
    );

    modport slave (
        input  req_valid, req_level,
        output req_ready, dec_out, enc_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/therm_level_seq.sv
`default_nettype none
// ============================================================================
//  Module   : therm_level_seq
//  Purpose  : Ramps a thermometer-encoder level one step per STEP_CYCLES clocks
//             toward a requested target; pulses done on arrival.
//  Revision : 1.0  initial release
// ============================================================================
module therm_level_seq #(
    parameter int LEVEL_W     = 3,
    parameter int STEP_CYCLES = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    therm_level_seq_if.slave  bus
);
    localparam int                 CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [LEVEL_W-1:0] dec_q,    dec_d;
    logic               en_q,     en_d;
    logic               ready_q,  ready_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               accept;

    assign accept = bus.req_valid & ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        dec_d    = dec_q;
        en_d     = en_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    target_d = bus.req_level;
                    cnt_d    = '0;
                    en_d     = 1'b1;
                    if (bus.req_level > dec_q) begin
                        state_d = RAMP_UP;
                    end else if (bus.req_level < dec_q) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        // Already at the target: report completion immediately.
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    dec_d = (state_q == RAMP_UP) ? (dec_q + LEVEL_ONE) : (dec_q - LEVEL_ONE);
                    if (dec_d == target_q) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next state's role.
        ready_d = (state_d == IDLE) || (state_d == HOLD);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            dec_q    <= '0;
            en_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            dec_q    <= dec_d;
            en_q     <= en_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.dec_out   = dec_q;
    assign bus.enc_en    = en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire
